// File: rtl/decoder_bcd.sv
// Registered 5-bit binary to two-digit BCD converter with a one-cycle valid strobe.
// The conversion uses shift-add-3 (double dabble), so there is no divider and no FSM.
module decoder_bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] in,
  input  logic       in_valid,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic       out_valid
);

  logic [12:0] dabble;
  logic [3:0]  units_c;
  logic [3:0]  tens_c;

  // Before each of the five shifts, any BCD column of 5 or more gets 3 added.
  // The binary value enters in bits [4:0]. After the last shift the tens digit
  // is in [12:9] and the units digit is in [8:5]. The largest input, 31, needs
  // only eight BCD bits, so nothing is shifted out of the top of the scratch word.
  always_comb begin
    dabble = {8'd0, in};
    for (int i = 0; i < 5; i++) begin
      if (dabble[8:5] >= 4'd5)
        dabble[8:5] = dabble[8:5] + 4'd3;
      if (dabble[12:9] >= 4'd5)
        dabble[12:9] = dabble[12:9] + 4'd3;
      dabble = dabble << 1;
    end
    units_c = dabble[8:5];
    tens_c  = dabble[12:9];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out0      <= 4'd0;
      out1      <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out0 <= units_c;
        out1 <= tens_c;
      end
    end
  end

endmodule

// File: tb/tb_decoder_bcd.sv
// Self-checking bench for decoder_bcd: a table of directed vectors, plus a sequence
// that changes the input between clock edges.
module tb_decoder_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] in;
  logic       in_valid;
  logic [3:0] out0;
  logic [3:0] out1;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  decoder_bcd dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] din;
    logic       vld;
    logic [3:0] e1;
    logic [3:0] e0;
    logic       ev;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input int d, input logic v,
                              input int t, input int u, input logic ev, input string n);
    vec_t x;
    x.rst = r; x.din = 5'(d); x.vld = v;
    x.e1 = 4'(t); x.e0 = 4'(u); x.ev = ev; x.name = n;
    return x;
  endfunction

  task automatic check(input string n, input logic [3:0] e1, input logic [3:0] e0, input logic ev);
    checks++;
    if (out1 !== e1 || out0 !== e0 || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: got out1=%0d out0=%0d out_valid=%0b, expected out1=%0d out0=%0d out_valid=%0b",
               n, out1, out0, out_valid, e1, e0, ev);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1; in = 5'd31; in_valid = 1'b1;

    // Reset held for three cycles while a valid 31 is presented.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 31, 1, 0, 0, 0, "reset_hold"));

    // Sweep 0..31. The expected digits come from comparing against 10, 20 and 30.
    for (int v = 0; v < 32; v++) begin
      t = (v >= 30) ? 3 : (v >= 20) ? 2 : (v >= 10) ? 1 : 0;
      vecs.push_back(mk(0, v, 1, t, v - t * 10, 1, $sformatf("sweep_%0d", v)));
    end
    // Hard-coded boundary cases.
    vecs.push_back(mk(0, 0,  1, 0, 0, 1, "bound_0"));
    vecs.push_back(mk(0, 9,  1, 0, 9, 1, "bound_9"));
    vecs.push_back(mk(0, 10, 1, 1, 0, 1, "bound_10"));
    vecs.push_back(mk(0, 31, 1, 3, 1, 1, "bound_31"));
    // Hold: load 27, then an idle cycle with in=5.
    vecs.push_back(mk(0, 27, 1, 2, 7, 1, "hold_load27"));
    vecs.push_back(mk(0, 5,  0, 2, 7, 0, "hold_idle"));
    vecs.push_back(mk(0, 5,  0, 2, 7, 0, "hold_idle2"));
    // Back-to-back samples.
    vecs.push_back(mk(0, 15, 1, 1, 5, 1, "b2b_15"));
    vecs.push_back(mk(0, 16, 1, 1, 6, 1, "b2b_16"));
    // Reset mid-stream: the sample presented during reset is discarded.
    vecs.push_back(mk(0, 31, 1, 3, 1, 1, "mid_load31"));
    vecs.push_back(mk(1, 22, 1, 0, 0, 0, "mid_reset22"));
    vecs.push_back(mk(0, 22, 1, 2, 2, 1, "mid_after22"));
    vecs.push_back(mk(0, 22, 0, 2, 2, 0, "mid_idle"));

    // Each vector is driven 1 time unit after an edge and checked 1 time unit after the next edge.
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; in = vecs[i].din; in_valid = vecs[i].vld;
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].e1, vecs[i].e0, vecs[i].ev);
    end

    // The outputs hold 2,2 with out_valid low. Changing in between edges must not affect them.
    in_valid = 1'b1; in = 5'd7;
    #2 check("glitch_a", 4'd2, 4'd2, 1'b0);
    in = 5'd13;
    #2 check("glitch_b", 4'd2, 4'd2, 1'b0);
    in = 5'd4;
    #2 check("glitch_c", 4'd2, 4'd2, 1'b0);
    @(posedge clk); #1;
    check("glitch_edge", 4'd0, 4'd4, 1'b1);
    in_valid = 1'b0; in = 5'd29;
    @(posedge clk); #1;
    check("glitch_idle", 4'd0, 4'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
